// File: rtl/mult_div_ctrl.sv
// +-----------------------------------------------------------------------------
// | mult_div_ctrl : iterative signed MULT/DIV sequencer for the HI/LO unit.
// | Optional macro: MULTDIV_FAST_ZERO_EN (zero-operand early completion).
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0_excp,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_a;
  logic               sign_b;
  logic               is_div;
  logic               div0;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               fast_zero;

  // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
  always_comb begin
    abs_a     = a_in[WIDTH-1] ? -a_in : a_in;
    abs_b     = b_in[WIDTH-1] ? -b_in : b_in;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

`ifdef MULTDIV_FAST_ZERO_EN
  assign fast_zero = op ? (a_in == '0) : ((a_in == '0) || (b_in == '0));
`else
  assign fast_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_a <= a_in[WIDTH-1];
            sign_b <= b_in[WIDTH-1];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            is_div <= op;
            cnt    <= '0;
            // divide-by-zero wins over the fast-zero shortcut
            if (op && (b_in == '0)) begin
              div0  <= 1'b1;
              state <= S_DONE;
            end else if (fast_zero) begin
              hi_out <= '0;
              lo_out <= '0;
              state  <= S_DONE;
            end else begin
              acc   <= op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
              state <= op ? S_DIV : S_MULT;
            end
          end
        end
        S_MULT: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= S_FIX;
        end
        S_DIV: begin
          if (!div_trial[WIDTH]) acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                   acc <= {acc[2*WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
          end else begin
            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
            lo_out <= prod_fix[WIDTH-1:0];
          end
          state <= S_DONE;
        end
        S_DONE: begin
          div0  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign div0_excp = (state == S_DONE) && div0;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_ctrl.sv
// +-----------------------------------------------------------------------------
// | tb_mult_div_ctrl : scoreboard bench for the MULT/DIV sequencer.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic        div0_excp;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .div0_excp (div0_excp),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

`ifdef MULTDIV_FAST_ZERO_EN
  localparam int ZLAT  = 0;
  localparam int ZBUSY = 1;
`else
  localparam int ZLAT  = 33;
  localparam int ZBUSY = 34;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        d0;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (div0_excp && !done) chk("div0_without_done", 64'(div0_excp), 64'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi_out", 64'(hi_out), 64'(e.hi));
        chk("lo_out", 64'(lo_out), 64'(e.lo));
        chk("div0_excp", 64'(div0_excp), 64'(e.d0));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic ed0,
                       input int lat, input int ebusy, input bit hold);
    exp_t e;
    int   nb;
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    e.hi = ehi; e.lo = elo; e.d0 = ed0; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    if (hold) begin
      op = 1'b1; a_in = 32'h1; b_in = 32'h1;
    end else begin
      start = 1'b0;
    end
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      if (done) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", 64'(nb), 64'(ebusy));
    chk("idle_after_op", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div0", 64'(div0_excp), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b1;

    issue(1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33, 34, 1'b0);

    // abort a MULT after its tenth step
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_in = 32'h0000_0007; b_in = 32'h0000_0009;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 34, 1'b0);
    issue(1'b1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 0, 1, 1'b0);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 34, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 34, 1'b0);
    issue(1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33, 34, 1'b0);
    issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 33, 34, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33, 34, 1'b0);
    issue(1'b0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, ZLAT, ZBUSY, 1'b0);
    issue(1'b0, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 1'b0, 33, 34, 1'b0);
    issue(1'b1, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, ZLAT, ZBUSY, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
